// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
// uart_rx_core_if : serial line and byte handshake between the UART receiver
//                   and its consumer. frm_err exists only with UART_RX_FRM_ERR_EN.
// Revision        : 1.0  initial release
// ============================================================================
interface uart_rx_core_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef UART_RX_FRM_ERR_EN
    logic       frm_err;

    modport master (output RX, output clr_rdy, input rx_data, input rdy, input frm_err);
    modport slave  (input RX, input clr_rdy, output rx_data, output rdy, output frm_err);
`else
    modport master (output RX, output clr_rdy, input rx_data, input rdy);
    modport slave  (input RX, input clr_rdy, output rx_data, output rdy);
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// uart_rx_core : 8N1 UART receiver; recovers one byte per frame, flags it on rdy.
// Config macro : UART_RX_FRM_ERR_EN adds frm_err (stop bit sampled low).
// Revision     : 1.0  initial release
// ============================================================================
module uart_rx_core #(
    parameter int BAUD_CNT  = 2604,
    parameter int HALF_BAUD = 1302
) (
    input wire logic      clk,
    input wire logic      rst_n,
    uart_rx_core_if.slave bus
);

    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  RCV       = 1'b1;
    localparam logic [11:0] BAUD_LOAD = 12'(BAUD_CNT);
    localparam logic [11:0] HALF_LOAD = 12'(HALF_BAUD);

    logic        rx_ff1;
    logic        rx_sync;
    logic [0:0]  state;
    logic [0:0]  next_state;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shft;
    logic        rdy_q;
    logic        start;
    logic        shift;
    logic        set_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ff1  <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_ff1  <= bus.RX;
            rx_sync <= rx_ff1;
        end
    end

    always_comb begin
        start      = 1'b0;
        set_rdy    = 1'b0;
        next_state = state;
        shift      = (state == RCV) && (baud_cnt == 12'd0);
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    start      = 1'b1;
                    next_state = RCV;
                end
            end
            RCV: begin
                // Tenth sample is the stop bit: frame done.
                if (shift && (bit_cnt == 4'd9)) begin
                    set_rdy    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= 12'd0;
            bit_cnt  <= 4'd0;
            shft     <= 9'h000;
        end else begin
            state <= next_state;
            if (start) begin
                baud_cnt <= HALF_LOAD;
                bit_cnt  <= 4'd0;
            end else if (shift) begin
                baud_cnt <= BAUD_LOAD;
                bit_cnt  <= bit_cnt + 4'd1;
            end else if (state == RCV) begin
                baud_cnt <= baud_cnt - 12'd1;
            end
            if (shift) begin
                shft <= {rx_sync, shft[8:1]};
            end
        end
    end

    // A new start wins over set_rdy, which in turn wins over the consumer's clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else if (start) begin
            rdy_q <= 1'b0;
        end else if (set_rdy) begin
            rdy_q <= 1'b1;
        end else if (bus.clr_rdy) begin
            rdy_q <= 1'b0;
        end
    end

`ifdef UART_RX_FRM_ERR_EN
    logic frm_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_err_q <= 1'b0;
        end else if (start) begin
            frm_err_q <= 1'b0;
        end else if (set_rdy) begin
            frm_err_q <= ~rx_sync;
        end
    end

    assign bus.frm_err = frm_err_q;
`endif

    assign bus.rx_data = shft[7:0];
    assign bus.rdy     = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_core : randomized frame stimulus against a frame-level reference
//                   model of the 8N1 receiver. Revision 1.0
// ============================================================================
module tb_uart_rx_core;

    localparam int BAUD = 31;
    localparam int HALF = 15;
    localparam int BIT  = BAUD + 1;
    // Clocks from driving the start bit low to rdy visible: 2 sync flops,
    // start-detect edge, half bit, nine bit-spaced samples, then the flag edge.
    localparam int LAT  = 4 + HALF + 9 * BIT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    uart_rx_core_if bus();

    uart_rx_core #(.BAUD_CNT(BAUD), .HALF_BAUD(HALF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic frm_err_obs;
`ifdef UART_RX_FRM_ERR_EN
    assign frm_err_obs = bus.frm_err;
`else
    assign frm_err_obs = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame at BIT clocks per bit; records when rdy rises and what
    // the byte/frm_err looked like at that moment.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int clr_at,
                              input int abort_after, output int rise, output logic rdy_at3,
                              output logic [7:0] data_at_rise, output logic err_at_rise);
        logic [9:0] bits;
        logic       prev;
        int         n;
        bits         = {stop, d, 1'b0};
        rise         = -1;
        rdy_at3      = 1'bx;
        data_at_rise = 8'hxx;
        err_at_rise  = 1'bx;
        n            = 0;
        prev         = bus.rdy;
        for (int k = 0; k < 10; k++) begin
            if (abort_after > 0 && k == abort_after) return;
            bus.RX = bits[k];
            for (int c = 0; c < BIT; c++) begin
                tick();
                n++;
                if (n == 3) rdy_at3 = bus.rdy;
                if (bus.rdy && !prev && rise < 0) begin
                    rise         = n;
                    data_at_rise = bus.rx_data;
                    err_at_rise  = frm_err_obs;
                end
                prev        = bus.rdy;
                bus.clr_rdy = (n == clr_at - 1);
            end
        end
        bus.RX      = 1'b1;
        bus.clr_rdy = 1'b0;
    endtask

    task automatic frame_checks(input string tag, input logic [7:0] d, input logic stop,
                                input int rise, input logic rdy_at3,
                                input logic [7:0] data_at_rise, input logic err_at_rise);
        check_val({tag, "_latency"}, rise, LAT);
        check_val({tag, "_start_clr"}, {31'd0, rdy_at3}, 32'd0);
        check_val({tag, "_data"}, {24'd0, data_at_rise}, {24'd0, d});
`ifdef UART_RX_FRM_ERR_EN
        check_val({tag, "_frm_err"}, {31'd0, err_at_rise}, {31'd0, ~stop});
`else
        if (err_at_rise === 1'bx) check_val({tag, "_err_x"}, 32'd1, 32'd0);
        if (stop === 1'bx) check_val({tag, "_stop_x"}, 32'd1, 32'd0);
`endif
    endtask

    // After a frame whose stop bit was low, the line is still low when the
    // receiver returns to idle, so it receives a phantom frame of all ones.
    task automatic expect_phantom(input string tag);
        repeat (LAT + 5) tick();
        check_val({tag, "_ph_rdy"}, {31'd0, bus.rdy}, 32'd1);
        check_val({tag, "_ph_data"}, {24'd0, bus.rx_data}, 32'h0000_00FF);
`ifdef UART_RX_FRM_ERR_EN
        check_val({tag, "_ph_frm_err"}, {31'd0, bus.frm_err}, 32'd0);
`endif
    endtask

    initial begin
        int         rise;
        logic       r3;
        logic [7:0] dr;
        logic       er;
        logic [7:0] d;
        logic       stop;
        int         gap;
        logic       do_clr;

        bus.RX      = 1'b1;
        bus.clr_rdy = 1'b0;
        rst_n       = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2000) tick();
        check_val("reset_rdy", {31'd0, bus.rdy}, 32'd0);
        check_val("reset_data", {24'd0, bus.rx_data}, 32'd0);
        check_val("reset_frm_err", {31'd0, frm_err_obs}, 32'd0);

        send_frame(8'hA5, 1'b1, 0, 0, rise, r3, dr, er);
        frame_checks("a5", 8'hA5, 1'b1, rise, r3, dr, er);
        check_val("a5_rdy_hold", {31'd0, bus.rdy}, 32'd1);

        bus.clr_rdy = 1'b1;
        tick();
        bus.clr_rdy = 1'b0;
        check_val("clr_rdy", {31'd0, bus.rdy}, 32'd0);
        check_val("clr_data_hold", {24'd0, bus.rx_data}, 32'h0000_00A5);
        repeat (5) tick();

        send_frame(8'h3C, 1'b1, LAT, 0, rise, r3, dr, er);
        frame_checks("clr_coll", 8'h3C, 1'b1, rise, r3, dr, er);
        check_val("clr_coll_rdy", {31'd0, bus.rdy}, 32'd1);

        send_frame(8'h00, 1'b1, 0, 0, rise, r3, dr, er);
        frame_checks("b2b0", 8'h00, 1'b1, rise, r3, dr, er);
        send_frame(8'hFF, 1'b1, 0, 0, rise, r3, dr, er);
        frame_checks("b2b1", 8'hFF, 1'b1, rise, r3, dr, er);
        check_val("b2b1_rdy", {31'd0, bus.rdy}, 32'd1);

        send_frame(8'h3C, 1'b0, 0, 0, rise, r3, dr, er);
        frame_checks("bad_stop", 8'h3C, 1'b0, rise, r3, dr, er);
        expect_phantom("bad_stop");

        send_frame(8'h77, 1'b1, 0, 5, rise, r3, dr, er);
        rst_n  = 1'b0;
        bus.RX = 1'b1;
        tick();
        rst_n = 1'b1;
        check_val("abort_rdy", {31'd0, bus.rdy}, 32'd0);
        check_val("abort_data", {24'd0, bus.rx_data}, 32'd0);
        repeat (10) tick();
        check_val("abort_idle_rdy", {31'd0, bus.rdy}, 32'd0);
        send_frame(8'h5A, 1'b1, 0, 0, rise, r3, dr, er);
        frame_checks("after_abort", 8'h5A, 1'b1, rise, r3, dr, er);

        bus.RX = 1'b0;
        repeat (3) tick();
        bus.RX = 1'b1;
        repeat (LAT + 5) tick();
        check_val("glitch_rdy", {31'd0, bus.rdy}, 32'd1);
        check_val("glitch_data", {24'd0, bus.rx_data}, 32'h0000_00FF);

        for (int i = 0; i < 24; i++) begin
            d      = 8'($urandom);
            stop   = ($urandom_range(0, 3) != 0);
            gap    = $urandom_range(0, 20);
            do_clr = ($urandom_range(0, 1) == 1) && (gap > 0);
            send_frame(d, stop, 0, 0, rise, r3, dr, er);
            frame_checks($sformatf("rnd%0d", i), d, stop, rise, r3, dr, er);
            if (!stop) begin
                expect_phantom($sformatf("rnd%0d", i));
            end else begin
                if (do_clr) begin
                    bus.clr_rdy = 1'b1;
                    tick();
                    bus.clr_rdy = 1'b0;
                    repeat (gap - 1) tick();
                end else begin
                    repeat (gap) tick();
                end
                check_val($sformatf("rnd%0d_rdy", i), {31'd0, bus.rdy}, {31'd0, ~do_clr});
                check_val($sformatf("rnd%0d_hold", i), {24'd0, bus.rx_data}, {24'd0, d});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
